qsfp_mgmt_ctrl: RTL and testbench

//   Sequences the QSFP28 low-speed management pins (ModSelL, ResetL, LPMode) from module presence.

---
 rtl/qsfp_mgmt_ctrl_if.sv | 28 ++
 rtl/qsfp_mgmt_ctrl.sv | 144 ++++++++++++++
 tb/tb_qsfp_mgmt_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/qsfp_mgmt_ctrl_if.sv
// Low-speed management bundle of one QSFP cage: pin-level signals plus the
// software-facing control/status lines. master = controller, slave = cage/software side.
interface qsfp_mgmt_ctrl_if;
  logic       qsfp_modprsl;
  logic       qsfp_intl;
  logic       soft_reset_req;
  logic       lpmode_req;
  logic       int_clear;
  logic       qsfp_modsell;
  logic       qsfp_resetl;
  logic       qsfp_lpmode;
  logic       module_present;
  logic       module_ready;
  logic       int_pending;
  logic [1:0] state;

  modport master (
    input  qsfp_modprsl, qsfp_intl, soft_reset_req, lpmode_req, int_clear,
    output qsfp_modsell, qsfp_resetl, qsfp_lpmode, module_present, module_ready,
           int_pending, state
  );

  modport slave (
    output qsfp_modprsl, qsfp_intl, soft_reset_req, lpmode_req, int_clear,
    input  qsfp_modsell, qsfp_resetl, qsfp_lpmode, module_present, module_ready,
           int_pending, state
  );
endinterface

// File: rtl/qsfp_mgmt_ctrl.sv
// QSFP28 management sequencer: debounced presence, timed ResetL pulse and init wait,
// module_ready gating for the datapath, and a latched IntL interrupt.
module qsfp_mgmt_ctrl #(
  parameter int DEBOUNCE_CYCLES = 125000,
  parameter int RESET_CYCLES    = 1250,
  parameter int INIT_CYCLES     = 250000000,
  parameter int CNT_W           = 28
) (
  input  logic                 clk,
  input  logic                 rst_n,
  qsfp_mgmt_ctrl_if.master     mgmt
);

  typedef enum logic [1:0] {
    ST_ABSENT = 2'd0,
    ST_RESET  = 2'd1,
    ST_INIT   = 2'd2,
    ST_READY  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RESET_LAST = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] INIT_LAST  = CNT_W'(INIT_CYCLES - 1);

  logic prs_meta, prs_sync;
  logic int_meta, int_sync, int_prev;
  logic int_fall;

  // Synchronisers reset to the idle pin levels (absent, no interrupt).
  // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prs_meta <= 1'b1;
      prs_sync <= 1'b1;
      int_meta <= 1'b1;
      int_sync <= 1'b1;
      int_prev <= 1'b1;
    end else begin
      prs_meta <= mgmt.qsfp_modprsl;
      prs_sync <= prs_meta;
      int_meta <= mgmt.qsfp_intl;
      int_sync <= int_meta;
      int_prev <= int_sync;
    end
  end

  assign int_fall = int_prev & ~int_sync;

  logic [CNT_W-1:0] deb_cnt;
  logic             present_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_cnt   <= '0;
      present_q <= 1'b0;
    end else if (~prs_sync == present_q) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DEB_LAST) begin
      present_q <= ~present_q;
      deb_cnt   <= '0;
    end else begin
      deb_cnt <= deb_cnt + 1'b1;
    end
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    if (!present_q) begin
      state_d = ST_ABSENT;
      timer_d = '0;
    end else if (mgmt.soft_reset_req && state_q != ST_ABSENT) begin
      state_d = ST_RESET;
      timer_d = '0;
    end else begin
      case (state_q)
        ST_ABSENT: begin
          state_d = ST_RESET;
          timer_d = '0;
        end
        ST_RESET: begin
          if (timer_q == RESET_LAST) begin
            state_d = ST_INIT;
            timer_d = '0;
          end else if (timer_q != '1) begin
            timer_d = timer_q + 1'b1;
          end
        end
        ST_INIT: begin
          if (timer_q == INIT_LAST) begin
            state_d = ST_READY;
            timer_d = '0;
          end else if (timer_q != '1) begin
            timer_d = timer_q + 1'b1;
          end
        end
        default: timer_d = '0;
      endcase
    end
  end

  logic resetl_q, modsell_q, lpmode_q, ready_q, int_pending_q;

  // Pin and status outputs are decoded from the next state so they flip on the same
  // edge as the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_ABSENT;
      timer_q       <= '0;
      resetl_q      <= 1'b0;
      modsell_q     <= 1'b1;
      lpmode_q      <= 1'b1;
      ready_q       <= 1'b0;
      int_pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      resetl_q  <= (state_d == ST_INIT) || (state_d == ST_READY);
      modsell_q <= (state_d != ST_READY);
      lpmode_q  <= (state_d == ST_READY) ? mgmt.lpmode_req : 1'b1;
      ready_q   <= (state_d == ST_READY);
      // A new interrupt wins over a simultaneous clear so it is never lost.
      if (state_d == ST_ABSENT)
        int_pending_q <= 1'b0;
      else if (state_q == ST_READY && int_fall)
        int_pending_q <= 1'b1;
      else if (mgmt.int_clear)
        int_pending_q <= 1'b0;
    end
  end

  assign mgmt.qsfp_resetl    = resetl_q;
  assign mgmt.qsfp_modsell   = modsell_q;
  assign mgmt.qsfp_lpmode    = lpmode_q;
  assign mgmt.module_present = present_q;
  assign mgmt.module_ready   = ready_q;
  assign mgmt.int_pending    = int_pending_q;
  assign mgmt.state          = state_q;

endmodule

// File: tb/tb_qsfp_mgmt_ctrl.sv
// Directed bench for qsfp_mgmt_ctrl with short timing parameters (debounce 4, reset 8, init 16).
module tb_qsfp_mgmt_ctrl;
  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_bad;
  logic seen;

  qsfp_mgmt_ctrl_if mgmt ();

  qsfp_mgmt_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .RESET_CYCLES   (8),
    .INIT_CYCLES    (16),
    .CNT_W          (8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .mgmt (mgmt.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance n rising edges and settle 1 time unit after the last one.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".state"},   32'(mgmt.state), 32'd0);
    check({tag, ".resetl"},  32'(mgmt.qsfp_resetl), 32'd0);
    check({tag, ".modsell"}, 32'(mgmt.qsfp_modsell), 32'd1);
    check({tag, ".lpmode"},  32'(mgmt.qsfp_lpmode), 32'd1);
    check({tag, ".ready"},   32'(mgmt.module_ready), 32'd0);
    check({tag, ".present"}, 32'(mgmt.module_present), 32'd0);
    check({tag, ".intpend"}, 32'(mgmt.int_pending), 32'd0);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b1;
    mgmt.qsfp_modprsl   = 1'b1;
    mgmt.qsfp_intl      = 1'b1;
    mgmt.soft_reset_req = 1'b0;
    mgmt.lpmode_req     = 1'b0;
    mgmt.int_clear      = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("rst");
    tick(2);
    rst_n = 1'b1;

    // 1: absent module stays in ABSENT; soft reset ignored there
    tick(20);
    check_reset_outputs("absent_idle");
    mgmt.soft_reset_req = 1'b1;
    tick(1);
    mgmt.soft_reset_req = 1'b0;
    tick(2);
    check("absent_softrst.state", 32'(mgmt.state), 32'd0);

    // 3: 3-cycle glitch never reaches module_present
    mgmt.qsfp_modprsl = 1'b0;
    tick(3);
    mgmt.qsfp_modprsl = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      seen = seen | mgmt.module_present | (mgmt.state != 2'd0);
    end
    check("glitch.present_or_state", 32'(seen), 32'd0);

    // 2: insertion, exact RESET and INIT dwell; IntL fall during INIT ignored
    mgmt.qsfp_modprsl = 1'b0;
    tick(5);
    check("ins.present_e5", 32'(mgmt.module_present), 32'd0);
    tick(1);
    check("ins.present_e6", 32'(mgmt.module_present), 32'd1);
    check("ins.state_e6", 32'(mgmt.state), 32'd0);
    tick(1);
    check("ins.state_e7", 32'(mgmt.state), 32'd1);
    check("ins.resetl_e7", 32'(mgmt.qsfp_resetl), 32'd0);
    tick(7);
    check("ins.state_e14", 32'(mgmt.state), 32'd1);
    check("ins.resetl_e14", 32'(mgmt.qsfp_resetl), 32'd0);
    tick(1);
    check("ins.state_e15", 32'(mgmt.state), 32'd2);
    check("ins.resetl_e15", 32'(mgmt.qsfp_resetl), 32'd1);
    check("ins.modsell_e15", 32'(mgmt.qsfp_modsell), 32'd1);
    tick(5);
    mgmt.qsfp_intl = 1'b0;
    tick(5);
    mgmt.qsfp_intl = 1'b1;
    tick(5);
    check("ins.state_e30", 32'(mgmt.state), 32'd2);
    check("ins.ready_e30", 32'(mgmt.module_ready), 32'd0);
    tick(1);
    check("ins.state_e31", 32'(mgmt.state), 32'd3);
    check("ins.ready_e31", 32'(mgmt.module_ready), 32'd1);
    check("ins.modsell_e31", 32'(mgmt.qsfp_modsell), 32'd0);
    check("ins.lpmode_e31", 32'(mgmt.qsfp_lpmode), 32'd0);
    check("init_int.intpend", 32'(mgmt.int_pending), 32'd0);
    mgmt.lpmode_req = 1'b1;
    tick(1);
    check("ready.lpmode_1", 32'(mgmt.qsfp_lpmode), 32'd1);
    mgmt.lpmode_req = 1'b0;
    tick(1);
    check("ready.lpmode_0", 32'(mgmt.qsfp_lpmode), 32'd0);

    // 4: interrupt latch; set beats clear; held-low IntL does not re-set
    mgmt.qsfp_intl = 1'b0;
    tick(2);
    check("int.before_sync", 32'(mgmt.int_pending), 32'd0);
    tick(1);
    check("int.set", 32'(mgmt.int_pending), 32'd1);
    mgmt.qsfp_intl = 1'b1;
    tick(4);
    mgmt.qsfp_intl = 1'b0;
    tick(2);
    mgmt.int_clear = 1'b1;
    tick(1);
    mgmt.int_clear = 1'b0;
    check("int.set_and_clear", 32'(mgmt.int_pending), 32'd1);
    tick(2);
    mgmt.int_clear = 1'b1;
    tick(1);
    mgmt.int_clear = 1'b0;
    check("int.clear", 32'(mgmt.int_pending), 32'd0);
    tick(5);
    check("int.held_low", 32'(mgmt.int_pending), 32'd0);
    mgmt.qsfp_intl = 1'b1;
    tick(3);

    // 5: soft reset from READY, then restarted mid-RESET
    mgmt.soft_reset_req = 1'b1;
    tick(1);
    mgmt.soft_reset_req = 1'b0;
    check("soft.state", 32'(mgmt.state), 32'd1);
    check("soft.ready", 32'(mgmt.module_ready), 32'd0);
    check("soft.resetl", 32'(mgmt.qsfp_resetl), 32'd0);
    check("soft.modsell", 32'(mgmt.qsfp_modsell), 32'd1);
    tick(4);
    mgmt.soft_reset_req = 1'b1;
    tick(1);
    mgmt.soft_reset_req = 1'b0;
    tick(7);
    check("restart.state_7", 32'(mgmt.state), 32'd1);
    check("restart.resetl_7", 32'(mgmt.qsfp_resetl), 32'd0);
    tick(1);
    check("restart.state_8", 32'(mgmt.state), 32'd2);
    tick(15);
    check("restart.init_15", 32'(mgmt.state), 32'd2);
    tick(1);
    check("restart.ready", 32'(mgmt.module_ready), 32'd1);

    // 6: removal mid-INIT clears interrupt; async reset mid-READY
    mgmt.qsfp_intl = 1'b0;
    tick(3);
    check("rm.intpend_set", 32'(mgmt.int_pending), 32'd1);
    mgmt.qsfp_intl = 1'b1;
    tick(3);
    mgmt.soft_reset_req = 1'b1;
    tick(1);
    mgmt.soft_reset_req = 1'b0;
    tick(8);
    check("rm.state_init", 32'(mgmt.state), 32'd2);
    check("rm.intpend_kept", 32'(mgmt.int_pending), 32'd1);
    tick(3);
    mgmt.qsfp_modprsl = 1'b1;
    tick(6);
    check("rm.present_e6", 32'(mgmt.module_present), 32'd0);
    tick(1);
    check("rm.state_e7", 32'(mgmt.state), 32'd0);
    check("rm.resetl_e7", 32'(mgmt.qsfp_resetl), 32'd0);
    check("rm.intpend_e7", 32'(mgmt.int_pending), 32'd0);

    mgmt.qsfp_modprsl = 1'b0;
    tick(31);
    check("reins.ready", 32'(mgmt.module_ready), 32'd1);
    mgmt.qsfp_modprsl = 1'b1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
